// File: rtl/intraloop_pkg.sv
// intraloop_pkg: shared widths, mode type and mode field indices for the intra loop
package intraloop_pkg;
  localparam int MB_W_DEF = 32;
  localparam int MODE_W_DEF = 3;
  localparam int NUM_MODES_DEF = 4;
  typedef logic [2:0] mode_t;
  localparam int MODE_IDX_L4X4 = 0;
  localparam int MODE_IDX_L16X16 = 1;
  localparam int MODE_IDX_CB = 2;
  localparam int MODE_IDX_CR = 3;
endpackage

// File: rtl/mb_tag_ram.sv
// mb_tag_ram: tag storage with synchronous write and asynchronous read
module mb_tag_ram #(
  parameter int DEPTH = 16,
  parameter int W = 44,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mb_tag_queue.sv
// mb_tag_queue: elastic FWFT queue of macroblock tags with occupancy, flush and sticky error flags
module mb_tag_queue
  import intraloop_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int MB_W = MB_W_DEF,
  parameter int MODE_W = MODE_W_DEF,
  parameter int NUM_MODES = NUM_MODES_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int MW = NUM_MODES * MODE_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [MB_W-1:0] push_mbnumber,
  input  logic [MW-1:0] push_modes,
  input  logic          pop,
  output logic          pop_valid,
  output logic [MB_W-1:0] pop_mbnumber,
  output logic [MW-1:0] pop_modes,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] high_water,
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow
);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, hw_q, hw_d, hw_base;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push_ok, pop_ok, we;
  logic [MW+MB_W-1:0] rdata;
  mb_tag_ram #(.DEPTH(DEPTH), .W(MW + MB_W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wr_q),
    .wdata({push_modes, push_mbnumber}),
    .raddr(rd_q),
    .rdata(rdata)
  );
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    push_ok = push && (!full || pop);
    pop_ok = pop && !empty;
    we = push_ok && !flush;
    wr_d = flush ? '0 : wr_q + AW'(push_ok);
    rd_d = flush ? '0 : rd_q + AW'(pop_ok);
    cnt_d = flush ? '0 : cnt_q + CW'(push_ok) - CW'(pop_ok);
    // set wins over err_clr; flush suppresses error events
    ovf_d = (ovf_q && !err_clr) || (!flush && push && full && !pop);
    unf_d = (unf_q && !err_clr) || (!flush && pop && empty);
    hw_base = err_clr ? '0 : hw_q;
    hw_d = cnt_d > hw_base ? cnt_d : hw_base;
    pop_valid = !empty;
    pop_mbnumber = empty ? '0 : rdata[MB_W-1:0];
    pop_modes = empty ? '0 : rdata[MW+MB_W-1:MB_W];
    count = cnt_q;
    high_water = hw_q;
    overflow = ovf_q;
    underflow = unf_q;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      hw_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      hw_q <= hw_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
endmodule

// File: tb/tb_mb_tag_queue.sv
// tb_mb_tag_queue: directed self-checking bench for mb_tag_queue
module tb_mb_tag_queue;
  logic        clk = 1'b0;
  logic        reset, flush, push, pop, err_clr;
  logic [31:0] push_mbnumber;
  logic [11:0] push_modes;
  logic        pop_valid, full, empty, overflow, underflow;
  logic [31:0] pop_mbnumber;
  logic [11:0] pop_modes;
  logic [4:0]  count, high_water;
  int n_cmp = 0;
  int n_err = 0;
  mb_tag_queue #(.DEPTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .push(push),
    .push_mbnumber(push_mbnumber),
    .push_modes(push_modes),
    .pop(pop),
    .pop_valid(pop_valid),
    .pop_mbnumber(pop_mbnumber),
    .pop_modes(pop_modes),
    .count(count),
    .full(full),
    .empty(empty),
    .high_water(high_water),
    .err_clr(err_clr),
    .overflow(overflow),
    .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic status(input string tag, input int c, input logic e, input logic f,
                        input logic o, input logic u, input int hw);
    chk({tag, ".count"}, 64'(count), 64'(c));
    chk({tag, ".empty"}, 64'(empty), 64'(e));
    chk({tag, ".pop_valid"}, 64'(pop_valid), 64'(!e));
    chk({tag, ".full"}, 64'(full), 64'(f));
    chk({tag, ".overflow"}, 64'(overflow), 64'(o));
    chk({tag, ".underflow"}, 64'(underflow), 64'(u));
    chk({tag, ".high_water"}, 64'(high_water), 64'(hw));
  endtask
  initial begin
    reset = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    push_mbnumber = '0; push_modes = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    status("reset", 0, 1, 0, 0, 0, 0);
    chk("reset.mb", 64'(pop_mbnumber), 64'd0);
    chk("reset.modes", 64'(pop_modes), 64'd0);
    push = 1'b1; push_mbnumber = 32'd5; push_modes = 12'h0E4;
    tick();
    push = 1'b0;
    status("single", 1, 0, 0, 0, 0, 1);
    chk("single.mb", 64'(pop_mbnumber), 64'd5);
    chk("single.modes", 64'(pop_modes), 64'h0E4);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    status("single_pop", 0, 1, 0, 0, 0, 1);
    chk("single_pop.mb", 64'(pop_mbnumber), 64'd0);
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; push_mbnumber = 32'(i); push_modes = 12'(i * 3);
      tick();
    end
    push = 1'b0;
    status("fill", 16, 0, 1, 0, 0, 16);
    chk("fill.head", 64'(pop_mbnumber), 64'd0);
    push = 1'b1; push_mbnumber = 32'd16;
    tick();
    push = 1'b0;
    status("drop", 16, 0, 1, 1, 0, 16);
    chk("drop.head", 64'(pop_mbnumber), 64'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    status("clr_full", 16, 0, 1, 0, 0, 16);
    push = 1'b1; pop = 1'b1; push_mbnumber = 32'd99; push_modes = 12'h7FF;
    tick();
    push = 1'b0; pop = 1'b0;
    status("full_pp", 16, 0, 1, 0, 0, 16);
    chk("full_pp.head", 64'(pop_mbnumber), 64'd1);
    for (int i = 1; i <= 16; i++) begin
      chk("drain.mb", 64'(pop_mbnumber), (i == 16) ? 64'd99 : 64'(i));
      chk("drain.modes", 64'(pop_modes), (i == 16) ? 64'h7FF : 64'(i * 3));
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    status("drained", 0, 1, 0, 0, 0, 16);
    push = 1'b1; pop = 1'b1; push_mbnumber = 32'd7; push_modes = 12'h123;
    tick();
    push = 1'b0; pop = 1'b0;
    status("empty_pp", 1, 0, 0, 0, 1, 16);
    chk("empty_pp.mb", 64'(pop_mbnumber), 64'd7);
    chk("empty_pp.modes", 64'(pop_modes), 64'h123);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    status("clr_empty", 1, 0, 0, 0, 0, 1);
    for (int i = 20; i < 25; i++) begin
      push = 1'b1; push_mbnumber = 32'(i);
      tick();
    end
    push = 1'b0;
    status("six", 6, 0, 0, 0, 0, 6);
    chk("six.head", 64'(pop_mbnumber), 64'd7);
    flush = 1'b1; push = 1'b1; push_mbnumber = 32'd55;
    tick();
    flush = 1'b0; push = 1'b0;
    status("flush", 0, 1, 0, 0, 0, 6);
    chk("flush.mb", 64'(pop_mbnumber), 64'd0);
    flush = 1'b1; pop = 1'b1;
    tick();
    flush = 1'b0; pop = 1'b0;
    status("flush_pop", 0, 1, 0, 0, 0, 6);
    for (int i = 30; i < 36; i++) begin
      push = 1'b1; push_mbnumber = 32'(i);
      tick();
    end
    push = 1'b0;
    status("refill", 6, 0, 0, 0, 0, 6);
    chk("refill.head", 64'(pop_mbnumber), 64'd30);
    reset = 1'b0; push = 1'b1; pop = 1'b1; push_mbnumber = 32'd77;
    tick();
    push = 1'b0; pop = 1'b0;
    status("midreset", 0, 1, 0, 0, 0, 0);
    chk("midreset.mb", 64'(pop_mbnumber), 64'd0);
    chk("midreset.modes", 64'(pop_modes), 64'd0);
    reset = 1'b1;
    push = 1'b1; push_mbnumber = 32'd42; push_modes = 12'h0A5;
    tick();
    push = 1'b0;
    status("post_reset", 1, 0, 0, 0, 0, 1);
    chk("post_reset.mb", 64'(pop_mbnumber), 64'd42);
    chk("post_reset.modes", 64'(pop_modes), 64'h0A5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
